// File: rtl/until_stim_gen.sv
// ---------------------------------------------------------------------------
// until_stim_gen
//
// Stimulus generator for "hold until event" checks. A start request makes
// hold_out stay high for H cycles and then release, while ev_out rises O
// cycles before the release (O=0 means it rises on the release edge, O>=H
// means it is high for the whole hold). With no_event set, ev_out is never
// raised for that sequence.
//
// Optional feature macro: UNTIL_STIM_GLITCH_EN
//   Adds input glitch_at. Inside the overlap window, the cycle whose
//   remaining-hold count equals glitch_at shows ev_out low, giving an event
//   that drops and re-rises before the hold releases.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   start        single-cycle request to begin a sequence
//   hold_cycles  H, number of hold cycles (latched on an accepted start)
//   overlap      O, number of final hold cycles with ev_out already high
//   no_event     suppress ev_out for this sequence
//   glitch_at    (UNTIL_STIM_GLITCH_EN only) count at which ev_out drops
//   hold_out     held signal, left operand of the until
//   ev_out       event signal, right operand of the until
//   busy         sequence in progress
//   done         one-cycle pulse when hold_out deasserts
//
// Handshake: start is a single-cycle request with no ready. It is accepted
// when the FSM is in IDLE or REL on the sampling edge; in RUN it is ignored.
//
// All outputs are flops decoded from the FSM state, so each output lags the
// internal state by one edge: start sampled at edge k -> FSM in RUN after
// edge k -> first RUN outputs visible after edge k+1.
// ---------------------------------------------------------------------------
module until_stim_gen #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [HOLD_W-1:0] overlap,
    input  logic              no_event,
`ifdef UNTIL_STIM_GLITCH_EN
    input  logic [HOLD_W-1:0] glitch_at,
`endif
    output logic              hold_out,
    output logic              ev_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] ovl_q, ovl_d;
    logic              ne_q, ne_d;
    logic              rel_first_q, rel_first_d;
    logic              accept;

    logic              hold_d, ev_d, busy_d, done_d;

`ifdef UNTIL_STIM_GLITCH_EN
    logic [HOLD_W-1:0] glitch_q, glitch_d;
`endif

    // ---------------------------------------------------------------
    // State register (also holds the latched sequence parameters and
    // the registered outputs).
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovl_q       <= '0;
            ne_q        <= 1'b0;
            rel_first_q <= 1'b0;
            hold_out    <= 1'b1;
            ev_out      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef UNTIL_STIM_GLITCH_EN
            glitch_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovl_q       <= ovl_d;
            ne_q        <= ne_d;
            rel_first_q <= rel_first_d;
            hold_out    <= hold_d;
            ev_out      <= ev_d;
            busy        <= busy_d;
            done        <= done_d;
`ifdef UNTIL_STIM_GLITCH_EN
            glitch_q    <= glitch_d;
`endif
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovl_d   = ovl_q;
        ne_d    = ne_q;
        accept  = 1'b0;
`ifdef UNTIL_STIM_GLITCH_EN
        glitch_d = glitch_q;
`endif
        case (state_q)
            IDLE, REL: begin
                if (start) begin
                    accept  = 1'b1;
                    cnt_d   = hold_cycles;
                    ovl_d   = overlap;
                    ne_d    = no_event;
`ifdef UNTIL_STIM_GLITCH_EN
                    glitch_d = glitch_at;
`endif
                    state_d = (hold_cycles == '0) ? REL : RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - HOLD_W'(1);
                // cnt is never 0 in RUN; <= guards against a corrupted count
                if (cnt_q <= HOLD_W'(1)) begin
                    state_d = REL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A fresh REL entry (from RUN, or a restart with H=0) earns one done.
        rel_first_d = (state_d == REL) && ((state_q == RUN) || accept);
    end

    // ---------------------------------------------------------------
    // Output decode (values registered on the next edge)
    // ---------------------------------------------------------------
    always_comb begin
        hold_d = 1'b1;
        ev_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            RUN: begin
                hold_d = 1'b1;
                busy_d = 1'b1;
                // cnt counts remaining hold cycles, so cnt<=O is the overlap
                // window; O>=H naturally covers every RUN cycle.
                ev_d   = (cnt_q <= ovl_q) && !ne_q;
`ifdef UNTIL_STIM_GLITCH_EN
                if (cnt_q == glitch_q) begin
                    ev_d = 1'b0;
                end
`endif
            end
            REL: begin
                hold_d = 1'b0;
                busy_d = 1'b0;
                ev_d   = !ne_q;
                done_d = rel_first_q;
            end
            default: begin
                hold_d = 1'b1;
                ev_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_until_stim_gen.sv
module tb_until_stim_gen;

    localparam int HOLD_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [HOLD_W-1:0] hold_cycles;
    logic [HOLD_W-1:0] overlap;
    logic              no_event;
    logic [HOLD_W-1:0] glitch_at;
    logic              hold_out;
    logic              ev_out;
    logic              busy;
    logic              done;

    until_stim_gen #(.HOLD_W(HOLD_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold_cycles (hold_cycles),
        .overlap     (overlap),
        .no_event    (no_event),
`ifdef UNTIL_STIM_GLITCH_EN
        .glitch_at   (glitch_at),
`endif
        .hold_out    (hold_out),
        .ev_out      (ev_out),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    // expected {hold_out, ev_out, busy, done} after each edge
    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    // Reference model: one record describing the most recently accepted
    // sequence, as edge number of acceptance plus its latched parameters.
    bit rec_valid = 0;
    int rec_k, rec_h, rec_o, rec_g;
    bit rec_ne;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got hold/ev/busy/done=%b expected %b (edge %0d)", tag, obs, exp, edge_n);
    endtask

    // Outputs visible after edge e, from the timeline of the current record.
    function automatic logic [3:0] model_out(int e);
        int d, rem;
        logic ev;
        if (!rec_valid) return 4'b1000;
        d = e - rec_k - 1;            // cycles since the first RUN output
        if (d < rec_h) begin
            rem = rec_h - d;          // hold cycles left including this one
            ev  = (rem <= rec_o) && !rec_ne;
            if (rem == rec_g) ev = 1'b0;
            return {1'b1, ev, 1'b1, 1'b0};
        end
        return {1'b0, !rec_ne, 1'b0, (d == rec_h)};
    endfunction

    task automatic model_edge(input logic s, input logic r);
        exp_q.push_back(r ? 4'b1000 : model_out(edge_n));
        if (r) begin
            rec_valid = 0;
        end else if (s && (!rec_valid || edge_n >= rec_k + rec_h + 1)) begin
            rec_valid = 1;
            rec_k  = edge_n;
            rec_h  = int'(hold_cycles);
            rec_o  = int'(overlap);
            rec_ne = no_event;
`ifdef UNTIL_STIM_GLITCH_EN
            rec_g  = int'(glitch_at);
`else
            rec_g  = -1;
`endif
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic r, input string tag);
        logic [3:0] e;
        start = s;
        rst   = r;
        @(posedge clk);
        edge_n++;
        model_edge(s, r);
        #1;
        e = exp_q.pop_front();
        check(tag, {hold_out, ev_out, busy, done}, e);
        // scramble parameter inputs: they must only matter on accepted starts
        start       = 1'b0;
        rst         = 1'b0;
        hold_cycles = HOLD_W'($urandom_range(0, 255));
        overlap     = HOLD_W'($urandom_range(0, 255));
        no_event    = 1'($urandom_range(0, 1));
        glitch_at   = HOLD_W'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    task automatic kick(input int h, input int o, input bit ne, input int g, input string tag);
        hold_cycles = HOLD_W'(h);
        overlap     = HOLD_W'(o);
        no_event    = ne;
        glitch_at   = HOLD_W'(g);
        step(1'b1, 1'b0, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0;
        hold_cycles = '0; overlap = '0; no_event = 1'b0; glitch_at = '0;

        step(1'b0, 1'b1, "reset");
        step(1'b0, 1'b1, "reset");
        idle(2, "idle");

        kick(10, 0, 0, 0, "plain");
        idle(15, "plain");

        kick(10, 2, 0, 0, "overlap2");
        idle(14, "overlap2");
        kick(10, 15, 0, 0, "overlap15");
        idle(14, "overlap15");

        kick(10, 0, 1, 0, "no_event");
        idle(25, "no_event");

        kick(0, 3, 0, 0, "h0");
        idle(2, "h0");
        kick(0, 0, 1, 0, "h0_rel_restart");
        kick(0, 0, 0, 0, "h0_rel_restart");
        idle(3, "h0");

        kick(10, 1, 0, 0, "start_in_run");
        idle(2, "start_in_run");
        kick(3, 9, 1, 0, "start_in_run");
        idle(3, "start_in_run");
        kick(2, 0, 1, 0, "start_in_run");
        idle(10, "start_in_run");

        // start sampled in the done cycle
        kick(4, 1, 0, 0, "back_to_back");
        idle(5, "back_to_back");
        kick(6, 2, 0, 0, "back_to_back");
        idle(10, "back_to_back");

        kick(10, 4, 0, 0, "rst_mid_run");
        idle(4, "rst_mid_run");
        step(1'b0, 1'b1, "rst_mid_run");
        idle(12, "rst_mid_run");

        kick(5, 5, 0, 0, "rst_and_start");
        idle(3, "rst_and_start");
        hold_cycles = 8'd3;
        step(1'b1, 1'b1, "rst_and_start");
        idle(6, "rst_and_start");

`ifdef UNTIL_STIM_GLITCH_EN
        kick(10, 3, 0, 2, "glitch");
        idle(14, "glitch");
        kick(10, 3, 0, 7, "glitch_outside");
        idle(14, "glitch_outside");
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            hold_cycles = HOLD_W'($urandom_range(0, 12));
            overlap     = HOLD_W'($urandom_range(0, 16));
            no_event    = ($urandom_range(0, 3) == 0);
            glitch_at   = HOLD_W'($urandom_range(0, 6));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
